// File: rtl/dm_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Runs one req/ack bus transaction per load/store, stalls the pipeline while
// it is in flight, aborts on timeout, replicates store data across lanes and
// aligns/extends load data before writeback.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [3:0]  Membe,
    input  logic        Sign,
    output logic        Stall,
    output logic [31:0] RData,
    output logic        RValid,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             acc;
    logic             misalign;
    logic             start;
    logic             timeout_hit;
    logic [31:0]      wdata_rep;
    logic [31:0]      rdata_aln;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;

    // Access decode, alignment check and timeout compare
    always_comb begin
        acc         = MemRead | MemWrite;
        misalign    = ((Membe == 4'b1111) && (Addr[1:0] != 2'b00)) ||
                      (((Membe == 4'b0011) || (Membe == 4'b1100)) && Addr[0]);
        timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    end

    // Store data lane replication by access width
    always_comb begin
        wdata_rep = WData;
        case (Membe)
            4'b1111:                            wdata_rep = WData;
            4'b0011, 4'b1100:                   wdata_rep = {2{WData[15:0]}};
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wdata_rep = {4{WData[7:0]}};
            default:                            wdata_rep = WData;
        endcase
    end

    // Load data lane select and sign/zero extension, keyed off latched lane enable
    always_comb begin
        rdata_aln = bus_rdata;
        half_sel  = bus_rdata[15:0];
        byte_sel  = bus_rdata[7:0];
        case (bus_be)
            4'b0011: begin
                half_sel  = bus_rdata[15:0];
                rdata_aln = {{16{sign_q & half_sel[15]}}, half_sel};
            end
            4'b1100: begin
                half_sel  = bus_rdata[31:16];
                rdata_aln = {{16{sign_q & half_sel[15]}}, half_sel};
            end
            4'b0001: begin
                byte_sel  = bus_rdata[7:0];
                rdata_aln = {{24{sign_q & byte_sel[7]}}, byte_sel};
            end
            4'b0010: begin
                byte_sel  = bus_rdata[15:8];
                rdata_aln = {{24{sign_q & byte_sel[7]}}, byte_sel};
            end
            4'b0100: begin
                byte_sel  = bus_rdata[23:16];
                rdata_aln = {{24{sign_q & byte_sel[7]}}, byte_sel};
            end
            4'b1000: begin
                byte_sel  = bus_rdata[31:24];
                rdata_aln = {{24{sign_q & byte_sel[7]}}, byte_sel};
            end
            default: rdata_aln = bus_rdata;
        endcase
    end

    // Next-state logic plus combinational Stall/AddrErr
    always_comb begin
        state_nx = state;
        Stall    = 1'b0;
        AddrErr  = 1'b0;
        start    = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    if (misalign) begin
                        AddrErr = 1'b1;
                    end else begin
                        Stall    = 1'b1;
                        start    = 1'b1;
                        state_nx = S_BUS;
                    end
                end
            end
            S_BUS: begin
                Stall = 1'b1;
                if (bus_ack || timeout_hit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                // Same instruction is still presented here; never reissue it
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Bus request, completion pulses and timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req <= 1'b0;
            RValid  <= 1'b0;
            BusErr  <= 1'b0;
            cnt     <= '0;
        end else begin
            bus_req <= (state_nx == S_BUS);
            RValid  <= (state == S_BUS) && (bus_ack || timeout_hit);
            BusErr  <= (state == S_BUS) && !bus_ack && timeout_hit;
            if (start) begin
                cnt <= '0;
            end else if ((state == S_BUS) && !bus_ack) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Transaction attributes held stable from launch until the next access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_we    <= 1'b0;
            bus_wdata <= '0;
            sign_q    <= 1'b0;
        end else if (start) begin
            bus_addr  <= {Addr[31:2], 2'b00};
            bus_be    <= Membe;
            bus_we    <= MemWrite;
            bus_wdata <= wdata_rep;
            sign_q    <= Sign;
        end
    end

    // Load writeback data; stores and timeouts leave it untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RData <= '0;
        end else if ((state == S_BUS) && bus_ack && !bus_we) begin
            RData <= rdata_aln;
        end
    end

endmodule
